// File: rtl/fpu_wb_initiator.sv
// Wishbone initiator that runs one FPU operation per command: write OPA/OPB/CTRL, poll STATUS,
// read RESULT. Define FPU_WB_INITIATOR_TIMEOUT_EN to add a per-cycle ack timeout.
module fpu_wb_initiator #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_i,
    input  logic [31:0] cmd_a_i,
    input  logic [31:0] cmd_b_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,

    output logic        busy_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_A    = 3'd1;
    localparam logic [2:0] WR_B    = 3'd2;
    localparam logic [2:0] WR_CTRL = 3'd3;
    localparam logic [2:0] RD_STAT = 3'd4;
    localparam logic [2:0] RD_RES  = 3'd5;
    localparam logic [2:0] RSP     = 3'd6;

    localparam logic [31:0] OFS_OPA    = 32'h00;
    localparam logic [31:0] OFS_OPB    = 32'h04;
    localparam logic [31:0] OFS_CTRL   = 32'h08;
    localparam logic [31:0] OFS_STATUS = 32'h0C;
    localparam logic [31:0] OFS_RESULT = 32'h10;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    logic [2:0]  state_q, state_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic        launch_we;
    logic [31:0] launch_adr;
    logic [31:0] launch_dat;

`ifdef FPU_WB_INITIATOR_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       timeout;

    // cnt_q holds the stalled cycles already seen, so the current one is the last allowed at TO_LAST.
    assign timeout = stb_q && !wbm_ack_i && (cnt_q == TO_LAST);

    always_comb begin
        cnt_d = 8'd0;
        if (stb_q && !wbm_ack_i && !timeout) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err_o = err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    // Transaction issued when a bus state is (re)entered with the strobe still low.
    always_comb begin
        launch_we  = 1'b1;
        launch_adr = BASE_ADDR + OFS_OPA;
        launch_dat = a_q;
        unique case (state_q)
            WR_B: begin
                launch_adr = BASE_ADDR + OFS_OPB;
                launch_dat = b_q;
            end
            WR_CTRL: begin
                launch_adr = BASE_ADDR + OFS_CTRL;
                launch_dat = {28'b0, op_q, 1'b1};
            end
            RD_STAT: begin
                launch_we  = 1'b0;
                launch_adr = BASE_ADDR + OFS_STATUS;
                launch_dat = 32'h0;
            end
            RD_RES: begin
                launch_we  = 1'b0;
                launch_adr = BASE_ADDR + OFS_RESULT;
                launch_dat = 32'h0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
`ifdef FPU_WB_INITIATOR_TIMEOUT_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    a_d     = cmd_a_i;
                    b_d     = cmd_b_i;
                    state_d = WR_A;
                    // OPA write starts straight from the accepted operand.
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = BASE_ADDR + OFS_OPA;
                    dat_d   = cmd_a_i;
                end
            end
            WR_A, WR_B, WR_CTRL, RD_STAT, RD_RES: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                    we_d  = launch_we;
                    adr_d = launch_adr;
                    dat_d = launch_dat;
                end else if (wbm_ack_i) begin
                    stb_d = 1'b0;
                    unique case (state_q)
                        WR_A:    state_d = WR_B;
                        WR_B:    state_d = WR_CTRL;
                        WR_CTRL: state_d = RD_STAT;
                        RD_STAT: begin
                            if (wbm_dat_i[0]) begin
                                state_d = RD_RES;
                            end
                        end
                        default: begin
                            state_d    = RSP;
                            rsp_data_d = wbm_dat_i;
`ifdef FPU_WB_INITIATOR_TIMEOUT_EN
                            err_d      = 1'b0;
`endif
                        end
                    endcase
`ifdef FPU_WB_INITIATOR_TIMEOUT_EN
                end else if (timeout) begin
                    stb_d      = 1'b0;
                    state_d    = RSP;
                    rsp_data_d = 32'h0;
                    err_d      = 1'b1;
`endif
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            op_q       <= 3'd0;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            rsp_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign wbm_cyc_o   = stb_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = stb_q ? 4'hF : 4'h0;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_valid_o = (state_q == RSP);
    assign rsp_data_o  = rsp_data_q;
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/fpu_wb_initiator.md
FPU_WB_INITIATOR -- requirements
Module: fpu_wb_initiator

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: FPU register base address.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum wait for wbm_ack_i per bus cycle (8-bit range, 1..255).
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  async reset, active low
REQ-004 SHALL have these command ports:
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted
- cmd_op_i  in  3  FPU opcode
- cmd_a_i  in  32  operand A
- cmd_b_i  in  32  operand B
REQ-005 SHALL have these response ports:
- rsp_valid_o  out  1  response held
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  32  result
- rsp_err_o  out  1  bus timeout
REQ-006 SHALL have these Wishbone master ports:
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte select
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge
REQ-007 SHALL have busy_o  out  1, high in every state except IDLE.

Function
REQ-008 SHALL use the FPU register map at BASE_ADDR offsets: 0x00 OPA, 0x04 OPB, 0x08 CTRL (bit0 start, bits[3:1] op), 0x0C STATUS (bit0 done), 0x10 RESULT.
REQ-009 SHALL implement the states IDLE, WR_A, WR_B, WR_CTRL, RD_STAT, RD_RES and RSP.
REQ-010 SHALL drive cmd_ready_o high only in IDLE; a command is accepted when cmd_valid_i and cmd_ready_o are both high, capturing op, a and b, with the next state WR_A.
REQ-011 SHALL run each bus state as one Wishbone classic cycle: cyc, stb, adr, we and dat held stable until the first wbm_ack_i, then cyc and stb deasserted for at least one cycle before the next transaction.
REQ-012 SHALL drive wbm_sel_o = 4'hF on every transaction; wbm_we_o is 1 for WR_* and 0 for RD_*.
REQ-013 SHALL use the sequence WR_A -> WR_B -> WR_CTRL (data {28'b0, op, 1'b1}) -> RD_STAT.
REQ-014 SHALL, in RD_STAT on ack, go to RD_RES if wbm_dat_i[0]=1, else re-issue RD_STAT after the one idle cycle.
REQ-015 SHALL, in RD_RES on ack, register wbm_dat_i into rsp_data_o with rsp_err_o=0, then go to RSP.
REQ-016 SHALL hold rsp_valid_o high in RSP with data and error stable until rsp_ready_i, then return to IDLE.
REQ-017 SHALL ignore wbm_ack_i while wbm_stb_o is low.
REQ-018 SHALL keep wbm_adr_o, wbm_dat_o and wbm_we_o unchanged while wbm_stb_o is high, regardless of a changing cmd_*_i.
REQ-019 SHALL accept no new command until the response handshake completes; minimum turnaround from command to rsp_valid_o is 10 cycles with zero-wait acks and done=1 on the first poll.

Reset
REQ-020 SHALL, on wb_rst_ni low, immediately force IDLE, cyc=stb=we=0, adr=dat=0, sel=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, and the timeout counter to 0.
REQ-021 SHALL abandon any in-flight bus cycle when reset is asserted mid-transaction, and issue no bus activity in the first cycle after release.

Configuration
REQ-022 SHALL provide macro FPU_WB_INITIATOR_TIMEOUT_EN.
REQ-023 SHALL, with FPU_WB_INITIATOR_TIMEOUT_EN defined, count cycles with stb high and ack low; at count == TIMEOUT_CYCLES, drop cyc/stb and go to RSP with rsp_err_o=1 and rsp_data_o=0.
REQ-024 SHALL, without FPU_WB_INITIATOR_TIMEOUT_EN, wait indefinitely for ack; rsp_err_o is tied to 0 and no counter is synthesized.

Verification
REQ-025 Scenario: op=1, a=32'h3F80_0000, b=32'h4000_0000, slave acks in 1 cycle, done on the first poll, result 32'h4040_0000 -> writes to 0x3000_0000, 0x3000_0004, and 0x3000_0008 with data 0x3, then reads of 0x3000_000C and 0x3000_0010; rsp_data_o=32'h4040_0000, rsp_err_o=0.
REQ-026 Scenario: STATUS returns 0 three times then 1 -> exactly four RD_STAT cycles, each separated by an idle cycle, then one RD_RES.
REQ-027 Scenario: rsp_ready_i held low for 20 cycles -> rsp_valid_o and rsp_data_o stable, cmd_ready_o=0, no bus activity; IDLE on the cycle after rsp_ready_i goes high.
REQ-028 Scenario (TIMEOUT_EN, TIMEOUT_CYCLES=8): no ack on WR_B -> stb high for exactly 8 cycles, then rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0, and no CTRL write.
REQ-029 Scenario: wb_rst_ni pulsed low during WR_CTRL with stb high -> cyc/stb low in the same cycle, busy_o=0, and a following command runs normally from WR_A.
REQ-030 Scenario: cmd_valid_i held high with changing operands during a transaction -> the second command is accepted only after the first response handshake, using the operand values present at acceptance.
